// File: rtl/uart_tx_fifo_if.sv
// Bundle between uart_tx_fifo and its producer/transmitter: write port,
// buffer status, and the launch/complete handshake to the serialiser.
interface uart_tx_fifo_if #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [DBIT-1:0]   wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              tx_start;
    logic [DBIT-1:0]   tx_din;
    logic              tx_done_tick;
    logic              busy;
    logic              ovf;

    // Producer and transmitter side.
    modport master (
        output wr_en, wr_data, tx_done_tick,
        input  full, empty, level, tx_start, tx_din, busy, ovf
    );

    // Buffer side.
    modport slave (
        input  wr_en, wr_data, tx_done_tick,
        output full, empty, level, tx_start, tx_din, busy, ovf
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Word buffer in front of a UART transmitter: queues producer words and launches
// them one at a time. Define UART_TX_FIFO_OVF_EN to build the sticky overflow flag.
module uart_tx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_WAIT_DONE
    } state_t;

    logic [DBIT-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_tx_start;
    logic [DBIT-1:0]   r_tx_din;
    state_t            r_state;
    state_t            w_state_next;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    // Status comes from the registered count only, so a pop in this cycle never frees a slot early.
    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);
    assign w_push  = bus.wr_en && !w_full;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.tx_done_tick) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: storage array has no reset; the cleared pointers and level make old contents unreachable.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_tx_start <= 1'b0;
            r_tx_din   <= '0;
            r_state    <= S_IDLE;
        end else begin
            r_state    <= w_state_next;
            r_tx_start <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                r_tx_din <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (bus.wr_en && w_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.level    = r_level;
    assign bus.tx_start = r_tx_start;
    assign bus.tx_din   = r_tx_din;
    assign bus.busy     = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted words are queued by the driver and
// popped by a monitor on every tx_start; occupancy is tracked as accepted - launched.
module tb_uart_tx_fifo;
    localparam int DBIT   = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef UART_TX_FIFO_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic reset;

    uart_tx_fifo_if #(.DBIT(DBIT), .ADDR_W(ADDR_W)) bus ();

    uart_tx_fifo #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int              checks = 0;
    int              errors = 0;
    logic [DBIT-1:0] exp_q[$];
    int              n_acc = 0;
    int              n_pop = 0;
    bit              m_ovf = 1'b0;
    bit              auto_done = 1'b0;
    bit              rand_dly = 1'b0;
    int              done_cnt = 0;
    logic            prev_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the falling edge, after the monitor has sampled.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [DBIT-1:0] d, input logic done);
        tick();
        bus.wr_en   = we;
        bus.wr_data = d;
        if (!auto_done) bus.tx_done_tick = done;
        if (we) begin
            if (n_acc - n_pop < DEPTH) begin
                exp_q.push_back(d);
                n_acc++;
            end else begin
                m_ovf = m_ovf | OVF_EN;
            end
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        n_acc    = 0;
        n_pop    = 0;
        m_ovf    = 1'b0;
        done_cnt = 0;
    endtask

    task automatic do_reset();
        tick();
        reset            = 1'b1;
        bus.wr_en        = 1'b0;
        bus.tx_done_tick = 1'b0;
        clear_model();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            drive(1'b0, '0, 1'b0);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d words still queued, expected 0", name, exp_q.size());
        end
        repeat (8) drive(1'b0, '0, 1'b0);
    endtask

    // Monitor: scoreboard pop on every launch plus occupancy/status checks each cycle.
    initial begin
        logic [DBIT-1:0] exp_word;
        int              lvl;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.tx_start) begin
                    check("tx_start_width", 32'(prev_start), 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_start_unexpected: got tx_din=0x%0h, expected no launch", bus.tx_din);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check("tx_din_order", 32'(bus.tx_din), 32'(exp_word));
                    end
                    n_pop++;
                    done_cnt = rand_dly ? int'($urandom_range(2, 6)) : 4;
                end
                prev_start = bus.tx_start;
                lvl = n_acc - n_pop;
                check("level", 32'(bus.level), lvl);
                check("full", 32'(bus.full), 32'(lvl == DEPTH));
                check("empty", 32'(bus.empty), 32'(lvl == 0));
                check("ovf", 32'(bus.ovf), 32'(m_ovf));
            end else begin
                prev_start = 1'b0;
            end
        end
    end

    // Transmitter model: completion pulse a programmable number of cycles after each launch.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (auto_done) begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    bus.tx_done_tick = (done_cnt == 0);
                end else begin
                    bus.tx_done_tick = 1'b0;
                end
            end
        end
    end

    initial begin
        reset            = 1'b1;
        bus.wr_en        = 1'b0;
        bus.wr_data      = '0;
        bus.tx_done_tick = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state.
        do_reset();
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_level", 32'(bus.level), 0);
        check("rst_tx_start", 32'(bus.tx_start), 0);
        check("rst_tx_din", 32'(bus.tx_din), 0);
        check("rst_ovf", 32'(bus.ovf), 0);

        // Single word: launch in the cycle after the edge following acceptance.
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("lat_level_n", 32'(bus.level), 1);
        check("lat_start_n", 32'(bus.tx_start), 0);
        drive(1'b0, '0, 1'b0);
        check("lat_start_n1", 32'(bus.tx_start), 1);
        check("lat_din_n1", 32'(bus.tx_din), 32'hA5);
        check("lat_busy_n1", 32'(bus.busy), 1);
        drive(1'b0, '0, 1'b0);
        check("lat_level_0", 32'(bus.level), 0);
        check("lat_start_pulse", 32'(bus.tx_start), 0);
        repeat (3) begin
            drive(1'b0, '0, 1'b0);
            check("lat_busy_wait", 32'(bus.busy), 1);
        end
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
        check("lat_busy_done", 32'(bus.busy), 0);

        // Fill: the first word launches at once, so 17 writes are needed to reach 16 held.
        do_reset();
        for (int i = 1; i <= DEPTH + 1; i++) drive(1'b1, DBIT'(i), 1'b0);
        drive(1'b0, '0, 1'b0);
        check("fill_full", 32'(bus.full), 1);
        check("fill_level", 32'(bus.level), DEPTH);
        check("fill_din_held", 32'(bus.tx_din), 32'h01);
        drive(1'b1, 8'hFF, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("fill_drop_level", 32'(bus.level), DEPTH);
        check("fill_ovf", 32'(bus.ovf), 32'(OVF_EN));

        // Drain with completion three cycles after each launch.
        bus.tx_done_tick = 1'b0;
        auto_done = 1'b1;
        drain("drain");
        check("drain_count", n_pop, DEPTH + 1);
        check("drain_empty", 32'(bus.empty), 1);
        check("drain_busy", 32'(bus.busy), 0);

        // Random writes with concurrent drain across several pointer wraps.
        auto_done = 1'b0;
        bus.tx_done_tick = 1'b0;
        do_reset();
        auto_done = 1'b1;
        rand_dly  = 1'b1;
        begin
            int guard = 0;
            while (n_acc < 40 && guard < 4000) begin
                drive(($urandom % 4) != 0, DBIT'($urandom), 1'b0);
                guard++;
            end
            check("rand_accepted", n_acc, 40);
        end
        drain("rand_drain");
        check("rand_count", n_pop, 40);
        check("rand_busy", 32'(bus.busy), 0);
        rand_dly  = 1'b0;
        auto_done = 1'b0;
        bus.tx_done_tick = 1'b0;

        // Reset while waiting on the transmitter with five words queued.
        do_reset();
        for (int i = 0; i < 6; i++) drive(1'b1, DBIT'(8'h30 + i), 1'b0);
        drive(1'b0, '0, 1'b0);
        check("mid_level", 32'(bus.level), 5);
        check("mid_busy", 32'(bus.busy), 1);
        tick();
        reset            = 1'b1;
        bus.wr_en        = 1'b1;
        bus.wr_data      = 8'h77;
        bus.tx_done_tick = 1'b1;
        clear_model();
        tick();
        reset            = 1'b0;
        bus.wr_en        = 1'b0;
        bus.tx_done_tick = 1'b0;
        check("mid_rst_level", 32'(bus.level), 0);
        check("mid_rst_start", 32'(bus.tx_start), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        drive(1'b0, '0, 1'b1);
        repeat (4) drive(1'b0, '0, 1'b0);
        check("late_done_no_start", n_pop, 0);
        drive(1'b1, 8'h5A, 1'b0);
        repeat (3) drive(1'b0, '0, 1'b0);
        check("post_rst_launch", n_pop, 1);
        check("post_rst_busy", 32'(bus.busy), 1);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
        check("post_rst_idle", 32'(bus.busy), 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
